// File: rtl/lrf_out_framer.sv
// Output framing stage behind the LRF fusion core. It re-tags the stream with tuser on the start of each frame and tlast on the end of each row.
// A 2-entry skid buffer isolates the core from sink backpressure. Define LRF_OUT_FRAMER_CHECKSUM_EN to add a per-frame byte checksum.
module lrf_out_framer #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [15:0]           frame_count,
  output logic                  tlast_err
`ifdef LRF_OUT_FRAMER_CHECKSUM_EN
  ,
  output logic [31:0]           frame_checksum,
  output logic                  checksum_valid
`endif
);

  localparam int BEATS_PER_ROW   = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int BEATS_PER_FRAME = BEATS_PER_ROW * IMAGE_DIM;
  localparam int COL_W = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int ROW_W = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_DIM - 1);

  if ((IMAGE_DIM % PIXELS_PER_BEAT) != 0 || BEATS_PER_FRAME < 1) begin : g_bad_cfg
    $error("lrf_out_framer: IMAGE_DIM must be a non-zero multiple of PIXELS_PER_BEAT");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
    logic                  eof;
  } beat_t;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  beat_t            main_q, main_d, skid_q, skid_d, in_beat;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             s_ready_q, s_ready_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             tlast_err_q, tlast_err_d;
  logic             accept, pop;
  logic             last_col, last_row, frame_end;

  assign accept = s_axis_tvalid & s_ready_q;
  assign pop    = main_valid_q & m_axis_tready;

  // Input tagging: position counters decide sof/eol/eof; an upstream tlast forces end of row and frame.
  always_comb begin
    last_col     = (col_q == COL_LAST);
    last_row     = (row_q == ROW_LAST);
    frame_end    = last_col & last_row;
    in_beat.data = s_axis_tdata;
    in_beat.sof  = (col_q == '0) && (row_q == '0);
    in_beat.eol  = last_col | s_axis_tlast;
    in_beat.eof  = frame_end | s_axis_tlast;
    tlast_err_d  = accept & (s_axis_tlast ^ frame_end);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (frame_end || s_axis_tlast) begin
        col_d = '0;
        row_d = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Main register feeds the output; the skid register only fills when main is stalled, so ready can be registered.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_d = in_beat;
        end
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
    s_ready_d     = ~skid_valid_d;
    frame_count_d = frame_count_q + {15'd0, pop & main_q.eof};
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      col_q         <= '0;
      row_q         <= '0;
      main_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
      s_ready_q     <= 1'b0;
      frame_count_q <= '0;
      tlast_err_q   <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      main_q        <= main_d;
      main_valid_q  <= main_valid_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      s_ready_q     <= s_ready_d;
      frame_count_q <= frame_count_d;
      tlast_err_q   <= tlast_err_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tvalid = main_valid_q;
  assign m_axis_tlast  = main_q.eol;
  assign m_axis_tuser  = main_q.sof;
  assign frame_count   = frame_count_q;
  assign tlast_err     = tlast_err_q;

`ifdef LRF_OUT_FRAMER_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] csum_q, csum_d;
  logic        csum_valid_q, csum_valid_d;
  logic [31:0] beat_sum;

  // Sums the bytes of the beat currently leaving the output register.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
      beat_sum = beat_sum + {24'd0, main_q.data[8*i +: 8]};
    end
  end

  always_comb begin
    acc_d        = acc_q;
    csum_d       = csum_q;
    csum_valid_d = 1'b0;
    if (pop) begin
      if (main_q.eof) begin
        csum_d       = acc_q + beat_sum;
        csum_valid_d = 1'b1;
        acc_d        = '0;
      end else begin
        acc_d = acc_q + beat_sum;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      acc_q        <= '0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      csum_q       <= csum_d;
      csum_valid_q <= csum_valid_d;
    end
  end

  assign frame_checksum = csum_q;
  assign checksum_valid = csum_valid_q;
`endif

endmodule

// File: tb/tb_lrf_out_framer.sv
// Directed scoreboard bench for lrf_out_framer at IMAGE_DIM=64, PIXELS_PER_BEAT=16 (4 beats per row, 256 per frame).
module tb_lrf_out_framer;
  localparam int PPB = 16;
  localparam int DIM = 64;
  localparam int DW  = 8*PPB;
  localparam int BW  = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [15:0]   frame_count;
  logic          tlast_err;
`ifdef LRF_OUT_FRAMER_CHECKSUM_EN
  logic [31:0]   frame_checksum;
  logic          checksum_valid;
  int            csum_pulses = 0;
  logic [31:0]   last_csum = '0;
`endif

  logic [BW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            err_pulses = 0;
  int            out_beats = 0;
  logic          stall_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] held = '0;

  lrf_out_framer #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .frame_count    (frame_count),
    .tlast_err      (tlast_err)
`ifdef LRF_OUT_FRAMER_CHECKSUM_EN
    ,
    .frame_checksum (frame_checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Sink ready: always 1, or the pattern 1,0,0,1 repeating while stall_en is set
  initial begin
    int ph;
    logic [3:0] pat;
    ph = 0;
    pat = 4'b1001;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        m_axis_tready = pat[3 - ph];
        ph = (ph + 1) % 4;
      end else begin
        m_axis_tready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold during stalls
  always @(negedge clk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] exp;
    cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (tlast_err) err_pulses++;
`ifdef LRF_OUT_FRAMER_CHECKSUM_EN
      if (checksum_valid) begin
        csum_pulses++;
        last_csum = frame_checksum;
      end
`endif
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || cur != held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h", m_axis_tvalid, cur, held);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        out_beats++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h with no expected beat queued", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur != exp) begin
            errors++;
            $display("FAIL out_beat %0d: got data=%h last=%0b user=%0b, required data=%h last=%0b user=%0b",
                     out_beats - 1, cur[BW-1:2], cur[1], cur[0], exp[BW-1:2], exp[1], exp[0]);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held = cur;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drive one beat and hold it until accepted; the expected output beat is queued at issue time
  task automatic send(input logic [DW-1:0] d, input logic last, input logic eu, input logic el);
    int budget;
    logic rdy;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    exp_q.push_back({d, el, eu});
    budget = 0;
    do begin
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk);
      #1;
      budget++;
    end while (!rdy && budget < 1000);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got tready=0 for %0d cycles, required 1", budget);
    end
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Beat i of a frame: tuser on i==0, tlast at every 4th beat or on the early-tlast beat
  task automatic send_frame(input int nbeats, input int tlast_at, input logic [7:0] tag,
                            input logic use_fill, input logic [7:0] fill, input logic chk_latency);
    logic [DW-1:0] d;
    logic [7:0]    idx;
    for (int i = 0; i < nbeats; i++) begin
      idx = 8'(i);
      d = use_fill ? {PPB{fill}} : {(PPB/2){tag, idx}};
      send(d, (i == tlast_at), (i == 0), ((i % 4) == 3) || (i == tlast_at));
      if (chk_latency && i == 0) chk("first_valid_latency", {31'd0, m_axis_tvalid}, 32'd1);
    end
    idle();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats still pending, required 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_m_tuser", {31'd0, m_axis_tuser}, 32'd0);
    chk("rst_m_tdata_nonzero", {31'd0, |m_axis_tdata}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_tlast_err", {31'd0, tlast_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s_tready_after_release", {31'd0, s_axis_tready}, 32'd1);

    // Full frame at full rate
    chk("m_tvalid_before_first", {31'd0, m_axis_tvalid}, 32'd0);
    base = out_beats;
    send_frame(256, 255, 8'h11, 1'b0, 8'h00, 1'b1);
    drain();
    chk("s1_out_beats", 32'(out_beats - base), 32'd256);
    chk("s1_frame_count", {16'd0, frame_count}, 32'd1);
    chk("s1_tlast_err", 32'(err_pulses), 32'd0);

    // Same frame with sink ready toggling 1,0,0,1
    stall_en = 1'b1;
    base = out_beats;
    send_frame(256, 255, 8'h22, 1'b0, 8'h00, 1'b0);
    drain();
    stall_en = 1'b0;
    chk("s2_out_beats", 32'(out_beats - base), 32'd256);
    chk("s2_frame_count", {16'd0, frame_count}, 32'd2);
    chk("s2_tlast_err", 32'(err_pulses), 32'd0);

    // Early tlast on beat 100, then a normal frame
    send_frame(101, 100, 8'h33, 1'b0, 8'h00, 1'b0);
    drain();
    chk("s3_tlast_err", 32'(err_pulses), 32'd1);
    chk("s3_frame_count", {16'd0, frame_count}, 32'd3);
    send_frame(256, 255, 8'h34, 1'b0, 8'h00, 1'b0);
    drain();
    chk("s3_next_frame_count", {16'd0, frame_count}, 32'd4);

    // Missing tlast, then a normal frame
    send_frame(256, -1, 8'h44, 1'b0, 8'h00, 1'b0);
    drain();
    chk("s4_tlast_err", 32'(err_pulses), 32'd2);
    chk("s4_frame_count", {16'd0, frame_count}, 32'd5);
    send_frame(256, 255, 8'h45, 1'b0, 8'h00, 1'b0);
    drain();
    chk("s4_next_frame_count", {16'd0, frame_count}, 32'd6);
    chk("s4_next_tlast_err", 32'(err_pulses), 32'd2);

    // Reset for one cycle after 50 beats; the in-flight beat is discarded
    send_frame(50, -1, 8'h55, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("s5_m_tvalid_in_reset", {31'd0, m_axis_tvalid}, 32'd0);
    chk("s5_frame_count_in_reset", {16'd0, frame_count}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(256, 255, 8'h56, 1'b0, 8'h00, 1'b0);
    drain();
    chk("s5_frame_count", {16'd0, frame_count}, 32'd1);
    chk("s5_tlast_err", 32'(err_pulses), 32'd2);

`ifdef LRF_OUT_FRAMER_CHECKSUM_EN
    send_frame(256, 255, 8'h66, 1'b1, 8'h01, 1'b0);
    drain();
    chk("csum_pulses_01", 32'(csum_pulses), 32'd1);
    chk("csum_01", last_csum, 32'd4096);
    send_frame(256, 255, 8'h67, 1'b1, 8'hFF, 1'b0);
    drain();
    chk("csum_pulses_ff", 32'(csum_pulses), 32'd2);
    chk("csum_ff", last_csum, 32'd1044480);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lrf_out_framer.md
Name: lrf_out_framer

Overview:
- Output framing stage directly downstream of the LRF fusion core.
- Consumes the fused-frame AXI-Stream, whose only marker is tlast at end of frame.
- Re-emits the stream with video-style markers: tuser on the first beat of each frame, tlast at end of each row.
- Isolates LRF from sink backpressure with a 2-entry skid buffer, checks upstream frame length and counts completed frames.

Parameters:
- PIXELS_PER_BEAT, 16, 8-bit pixels per beat.
- IMAGE_DIM, 512, frame is IMAGE_DIM x IMAGE_DIM pixels.
- DATA_WIDTH, 8*PIXELS_PER_BEAT, stream data width.
- Derived (localparam):
  - BEATS_PER_ROW = IMAGE_DIM/PIXELS_PER_BEAT
  - BEATS_PER_FRAME = BEATS_PER_ROW*IMAGE_DIM
- IMAGE_DIM must be a multiple of PIXELS_PER_BEAT (elaboration error otherwise).

Ports:
- s_axis_aclk  in  1  clock.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  fused pixels from LRF.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  ready to upstream.
- s_axis_tlast  in  1  upstream end-of-frame.
- m_axis_tdata  out  DATA_WIDTH  pixels to sink.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  end of row.
- m_axis_tuser  out  1  start of frame.
- frame_count  out  16  frames fully delivered downstream; wraps 0xFFFF->0.
- tlast_err  out  1  one-cycle pulse on upstream frame-length violation.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - m_axis_tvalid, m_axis_tlast, m_axis_tuser, tlast_err = 0; m_axis_tdata = 0; frame_count = 0.
  - Input beat counters cleared; skid buffer emptied.
  - s_axis_tready = 0 while reset is asserted, 1 from the first clock edge after release.
- Reset mid-frame: in-flight beats are discarded. The next accepted beat is treated as the start of a frame.
- Input tagging, on each accepted beat (s_axis_tvalid & s_axis_tready):
  - Column counter col (0..BEATS_PER_ROW-1) and row counter row (0..IMAGE_DIM-1) advance.
  - sof = (col==0 && row==0).
  - eol = (col==BEATS_PER_ROW-1) or (s_axis_tlast accepted early).
  - eof = (col, row at last) or (s_axis_tlast).
  - {data, sof, eol, eof} are stored together in the buffer.
- Wrap: after the last beat of a frame, col and row return to 0.
- Early tlast (s_axis_tlast on a beat before frame end):
  - tlast_err pulses the cycle after acceptance.
  - That beat is tagged eol+eof; counters resync to 0.
- Missing tlast (last frame beat without s_axis_tlast):
  - tlast_err pulses; beat still tagged eol+eof; counters wrap normally.
- Skid buffer (main + skid register):
  - Latency from input accept to m_axis_tvalid: 1 cycle.
  - s_axis_tready is registered: it is 0 exactly when the skid register holds data.
  - A full-rate stream with m_axis_tready=1 moves one beat per cycle with no bubbles.
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast/tuser are held stable.
  - Buffer never drops or duplicates a beat.
  - When both registers are full, s_axis_tready=0 until an output handshake occurs.
- Simultaneous input accept and output handshake: the buffer keeps its occupancy, data moves in order.
- frame_count increments on the output handshake of an eof-tagged beat. This is independent of tlast_err.

Optional Feature:
- Macro LRF_OUT_FRAMER_CHECKSUM_EN.
- Defined:
  - Adds output frame_checksum [31:0] and output checksum_valid (1).
  - Per frame, accumulates the unsigned sum of all pixel bytes of beats handshaked on the output side (modulo 2^32).
  - On the eof beat handshake, frame_checksum latches the total including that beat; checksum_valid pulses 1 cycle; the accumulator restarts at 0.
  - Both outputs reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Directed scenarios use IMAGE_DIM=64, PIXELS_PER_BEAT=16, so BEATS_PER_ROW=4 and BEATS_PER_FRAME=256.
- Reset then one full frame at full rate, tlast on beat 255 ->
  - m_axis_tuser=1 only on out beat 0; m_axis_tlast on out beats 3,7,...,255 (64 pulses).
  - frame_count=1; tlast_err never 1; first m_axis_tvalid 1 cycle after first accept.
- Same frame with m_axis_tready toggling 1,0,0,1 repeating ->
  - Output sequence identical, beat order preserved, data stable during stalls.
  - s_axis_tready drops only while skid full; 256 beats out.
- s_axis_tlast on beat 100 (row 25, col 0) ->
  - tlast_err pulse; beat 100 out with m_axis_tlast=1; frame_count=1.
  - Next beat out with m_axis_tuser=1.
- 256 beats with no tlast, then second frame ->
  - tlast_err pulse at beat 255; frame_count=1; second frame starts with m_axis_tuser=1.
- s_axis_aresetn low for 1 cycle after 50 beats of a frame ->
  - m_axis_tvalid=0 immediately, frame_count=0.
  - Next accepted beat is tagged sof.
- With LRF_OUT_FRAMER_CHECKSUM_EN, frame of all bytes 0x01 -> frame_checksum=4096, checksum_valid one pulse. With all bytes 0xFF -> 1044480.
